// File: rtl/sdf_query_arbiter_if.sv
// Bundles the core-facing request/response signals and the sdf_query-facing signals of the arbiter.
interface sdf_query_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int FP_W  = 32
);
  localparam int VEC_W = 3 * FP_W;

  logic [2:0]                   fractal_sel_in;
  logic [N_REQ-1:0]             req_valid_in;
  logic [N_REQ-1:0][VEC_W-1:0]  req_point_in;
  logic [N_REQ-1:0]             req_ready_out;
  logic [N_REQ-1:0]             resp_valid_out;
  logic [FP_W-1:0]              resp_sdf_out;
  logic [VEC_W-1:0]             sdf_point_out;
  logic [2:0]                   sdf_fractal_sel_out;
  logic [FP_W-1:0]              sdf_in;
  logic [5:0]                   sdf_wait_max_in;
  logic                         busy_out;

  modport slave (
    input  fractal_sel_in, req_valid_in, req_point_in, sdf_in, sdf_wait_max_in,
    output req_ready_out, resp_valid_out, resp_sdf_out, sdf_point_out,
           sdf_fractal_sel_out, busy_out
  );

  modport master (
    output fractal_sel_in, req_valid_in, req_point_in, sdf_in, sdf_wait_max_in,
    input  req_ready_out, resp_valid_out, resp_sdf_out, sdf_point_out,
           sdf_fractal_sel_out, busy_out
  );
endinterface

// File: rtl/sdf_query_arbiter.sv
// Round-robin arbiter sharing one pipelined sdf_query among N_REQ cores; owner tags ride a delay
// line tapped at the SDF latency, and fractal changes drain the pipeline before retargeting.
module sdf_query_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LAT = 8,
  parameter int FP_W    = 32
) (
  input logic                clk_in,
  input logic                rst_in,
  sdf_query_arbiter_if.slave bus
);
  localparam int VEC_W = 3 * FP_W;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int LAT_W = $clog2(MAX_LAT);
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWITCH} state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                last_q;
  logic [2:0]                      sel_q, sel_d;
  logic [MAX_LAT-1:0]              tag_vld_q;
  logic [MAX_LAT-1:0][IDX_W-1:0]   tag_id_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [VEC_W-1:0]                point_q;
  logic [FP_W-1:0]                 resp_sdf_q;
  logic [N_REQ-1:0]                resp_vld_q;
  logic                            busy_q, busy_d;

  logic                            mismatch;
  logic                            grant_any;
  logic [IDX_W-1:0]                grant_idx;
  logic [N_REQ-1:0]                grant;
  logic [LAT_W-1:0]                lat;
  logic                            tap_vld;
  logic [IDX_W-1:0]                tap_id;

  // Search starts one past the last winner so every requester waits at most N_REQ-1 grants.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    mismatch  = (state_q == S_RUN) && (bus.fractal_sel_in != sel_q);
    if (state_q == S_RUN && !mismatch) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!grant_any && bus.req_valid_in[(int'(last_q) + k) % N_REQ]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'((int'(last_q) + k) % N_REQ);
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    lat = LAT_W'(MAX_LAT - 1);
    if (bus.sdf_wait_max_in == '0) lat = LAT_W'(1);
    else if (int'(bus.sdf_wait_max_in) < MAX_LAT) lat = LAT_W'(bus.sdf_wait_max_in);
  end

  assign tap_vld = tag_vld_q[lat];
  assign tap_id  = tag_id_q[lat];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q + CNT_W'(grant_any) - CNT_W'(tap_vld);
    busy_d  = (cnt_q != '0) || (state_q != S_RUN) || mismatch;
    case (state_q)
      S_RUN:    if (mismatch) state_d = S_DRAIN;
      S_DRAIN:  if (cnt_q == '0) state_d = S_SWITCH;
      S_SWITCH: begin
        // Re-latches whatever is requested now, even if it reverted during the drain.
        sel_d   = bus.fractal_sel_in;
        state_d = S_RUN;
      end
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_RUN;
      last_q     <= IDX_W'(N_REQ - 1);
      sel_q      <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      cnt_q      <= '0;
      point_q    <= '0;
      resp_sdf_q <= '0;
      resp_vld_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      tag_vld_q <= {tag_vld_q[MAX_LAT-2:0], grant_any};
      tag_id_q  <= {tag_id_q[MAX_LAT-2:0], grant_idx};
      if (grant_any) begin
        last_q  <= grant_idx;
        point_q <= bus.req_point_in[grant_idx];
      end
      if (tap_vld) begin
        resp_sdf_q <= bus.sdf_in;
        resp_vld_q <= N_REQ'(1) << tap_id;
      end else begin
        resp_vld_q <= '0;
      end
    end
  end

  assign bus.req_ready_out       = grant;
  assign bus.resp_valid_out      = resp_vld_q;
  assign bus.resp_sdf_out        = resp_sdf_q;
  assign bus.sdf_point_out       = point_q;
  assign bus.sdf_fractal_sel_out = sel_q;
  assign bus.busy_out            = busy_q;
endmodule

// File: tb/tb_sdf_query_arbiter.sv
// Drives the arbiter against a behavioural pipelined SDF model and scoreboards every response.
module tb_sdf_query_arbiter;
  localparam int N  = 4;
  localparam int ML = 8;
  localparam int FW = 32;
  localparam int VW = 3 * FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdf_query_arbiter_if #(.N_REQ(N), .FP_W(FW)) bus ();
  sdf_query_arbiter #(.N_REQ(N), .MAX_LAT(ML), .FP_W(FW)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SDF model: per-selection raw wait, clamped latency, and a simple distance function.
  function automatic int wait_of(input logic [2:0] s);
    case (s)
      3'd0: return 4;
      3'd1: return 1;
      3'd2: return 1;
      3'd3: return 5;
      3'd7: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int eff_lat(input logic [2:0] s);
    int w;
    w = wait_of(s);
    if (w < 1) return 1;
    if (w > ML - 1) return ML - 1;
    return w;
  endfunction

  function automatic logic [FW-1:0] sdf_fn(input logic [VW-1:0] p, input logic [2:0] s);
    return (p[31:0] ^ p[63:32] ^ p[95:64]) + 32'(s) * 32'h0101_0101;
  endfunction

  logic [VW-1:0] pipe [ML];
  always @(posedge clk) begin
    pipe[0] <= bus.sdf_point_out;
    for (int k = 1; k < ML; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.sdf_wait_max_in = 6'(wait_of(bus.sdf_fractal_sel_out));
  assign bus.sdf_in = sdf_fn(pipe[eff_lat(bus.sdf_fractal_sel_out) - 1], bus.sdf_fractal_sel_out);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected owner, distance and arrival cycle of every handshake.
  typedef struct {
    int            id;
    logic [FW-1:0] sdf;
    int            due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int   mon_id;

  always @(negedge clk) begin
    if (bus.resp_valid_out != '0) begin
      resp_pulses++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL resp_spurious: resp_valid=%b with nothing outstanding at cycle %0d",
                 bus.resp_valid_out, cyc);
      end else begin
        mon_e = q.pop_front();
        if (bus.resp_valid_out !== (N'(1) << mon_e.id) || bus.resp_sdf_out !== mon_e.sdf ||
            cyc != mon_e.due) begin
          errors++;
          $display("FAIL resp_match: valid=%b sdf=%h cycle=%0d expected valid=%b sdf=%h cycle=%0d",
                   bus.resp_valid_out, bus.resp_sdf_out, cyc, N'(1) << mon_e.id, mon_e.sdf, mon_e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due == cyc) begin
      checks++;
      errors++;
      mon_e = q.pop_front();
      $display("FAIL resp_missing: no response at cycle %0d expected valid=%b", cyc, N'(1) << mon_e.id);
    end
    checks++;
    if ((bus.req_ready_out & ~bus.req_valid_in) != '0 || $countones(bus.req_ready_out) > 1) begin
      errors++;
      $display("FAIL ready_legal: ready=%b valid=%b", bus.req_ready_out, bus.req_valid_in);
    end
    if (rst) q.delete();
    else if ((bus.req_ready_out & bus.req_valid_in) != '0) begin
      mon_id = 0;
      for (int c = 0; c < N; c++) if (bus.req_ready_out[c]) mon_id = c;
      q.push_back('{mon_id, sdf_fn(bus.req_point_in[mon_id], bus.sdf_fractal_sel_out),
                    cyc + eff_lat(bus.sdf_fractal_sel_out) + 2});
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic new_points();
    for (int c = 0; c < N; c++) bus.req_point_in[c] = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_quiet(input string name);
    bit done;
    done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy_out) done = 1;
    end
    chk({name, "_quiet"}, 128'(done), 128'(1));
    next_edge();
  endtask

  // Waits for a grant, then measures negedges from it to its response.
  task automatic single_query(input string name, input logic [N-1:0] vld, input int exp_dly);
    bit got;
    int hs;
    int d;
    got = 0;
    hs  = 0;
    d   = 0;
    new_points();
    bus.req_valid_in = vld;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready_out != '0) begin got = 1; hs = cyc; end
      else next_edge();
    end
    chk({name, "_grant"}, 128'(bus.req_ready_out), 128'(vld));
    next_edge();
    bus.req_valid_in = '0;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.resp_valid_out != '0) begin got = 1; d = cyc - hs; end
    end
    chk({name, "_delay"}, 128'(d), 128'(exp_dly));
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] rdy;
  } vec_t;
  vec_t tbl [15];

  int stalls;
  int grants;
  logic busy_drain;
  logic [2:0] sel_resume;

  initial begin
    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};
    tbl[7]  = '{4'b1110, 4'b0010};
    tbl[8]  = '{4'b1110, 4'b0100};
    tbl[9]  = '{4'b1010, 4'b1000};
    tbl[10] = '{4'b1010, 4'b0010};
    tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b0100, 4'b0100};
    tbl[13] = '{4'b1001, 4'b1000};
    tbl[14] = '{4'b1001, 4'b0001};

    rst = 1'b1;
    bus.fractal_sel_in = 3'd0;
    bus.req_valid_in   = '0;
    bus.req_point_in   = '0;
    repeat (3) next_edge();
    @(negedge clk);
    chk("rst_ready",     128'(bus.req_ready_out),       128'(0));
    chk("rst_resp_vld",  128'(bus.resp_valid_out),      128'(0));
    chk("rst_resp_sdf",  128'(bus.resp_sdf_out),        128'(0));
    chk("rst_point",     128'(bus.sdf_point_out),       128'(0));
    chk("rst_sel",       128'(bus.sdf_fractal_sel_out), 128'(0));
    chk("rst_busy",      128'(bus.busy_out),            128'(0));
    next_edge();
    rst = 1'b0;

    // Round-robin grant order with full, sparse and intermittent requesters.
    for (int i = 0; i < 15; i++) begin
      bus.req_valid_in = tbl[i].vld;
      new_points();
      @(negedge clk);
      chk($sformatf("rr_grant%0d", i), 128'(bus.req_ready_out), 128'(tbl[i].rdy));
      next_edge();
    end
    bus.req_valid_in = '0;
    wait_quiet("rr");

    // Core 0 alone with sel 1 (L=1).
    bus.fractal_sel_in = 3'd1;
    single_query("sel1_single", 4'b0001, 3);
    chk("sel1_active", 128'(bus.sdf_fractal_sel_out), 128'(1));
    wait_quiet("sel1");

    // Back-to-back issue/response overlap, then a one-cycle sel pulse that reverts during DRAIN.
    new_points();
    bus.req_valid_in = 4'b0001;
    repeat (6) next_edge();
    bus.fractal_sel_in = 3'd2;
    stalls = 0;
    busy_drain = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.req_ready_out != '0) break;
      stalls++;
      if (stalls == 2) busy_drain = bus.busy_out;
      next_edge();
      bus.fractal_sel_in = 3'd1;
    end
    chk("pulse_stalls", 128'(stalls), 128'(4));
    chk("pulse_busy", 128'(busy_drain), 128'(1));
    chk("pulse_sel", 128'(bus.sdf_fractal_sel_out), 128'(1));
    next_edge();
    bus.req_valid_in = '0;
    wait_quiet("pulse");

    // Switch to sel 0, issue four queries, then retarget to sel 3 with them in flight.
    bus.fractal_sel_in = 3'd0;
    bus.req_valid_in = 4'b1111;
    new_points();
    grants = 0;
    for (int t = 0; t < 40 && grants < 4; t++) begin
      @(negedge clk);
      if (bus.req_ready_out != '0) grants++;
      next_edge();
    end
    chk("sw_grants", 128'(grants), 128'(4));
    bus.fractal_sel_in = 3'd3;
    stalls = 0;
    sel_resume = 3'd0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.req_ready_out != '0) break;
      stalls++;
      next_edge();
    end
    sel_resume = bus.sdf_fractal_sel_out;
    chk("sw_stalls", 128'(stalls), 128'(7));
    chk("sw_sel", 128'(sel_resume), 128'(3));
    next_edge();
    bus.req_valid_in = '0;
    wait_quiet("sw");
    single_query("sel3_single", 4'b0100, 7);
    wait_quiet("sel3");

    // Reset with three sel-0 queries in flight.
    bus.fractal_sel_in = 3'd0;
    bus.req_valid_in = 4'b0111;
    grants = 0;
    for (int t = 0; t < 40 && grants < 3; t++) begin
      @(negedge clk);
      if (bus.req_ready_out != '0) grants++;
      next_edge();
    end
    bus.req_valid_in = '0;
    rst = 1'b1;
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy0", 128'(bus.busy_out), 128'(0));
    stalls = resp_pulses;
    @(negedge clk);
    chk("rstmid_busy1", 128'(bus.busy_out), 128'(0));
    repeat (12) @(negedge clk);
    chk("rstmid_no_resp", 128'(resp_pulses - stalls), 128'(0));
    next_edge();

    // Selection whose raw wait is 0 must behave as latency 1.
    bus.fractal_sel_in = 3'd7;
    single_query("clamp_single", 4'b1000, 3);
    chk("clamp_sel", 128'(bus.sdf_fractal_sel_out), 128'(7));
    wait_quiet("clamp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdf_query_arbiter.md
# sdf_query_arbiter

Round-robin arbiter and sequencer that shares one `sdf_query` instance among `N_REQ` ray-marcher cores. It issues at most one point per cycle into the fully pipelined SDF datapath and tracks the owner of each in-flight query in a tag delay line. It routes each returned distance back to its owner. It also serialises fractal-selection changes by draining the pipeline before retargeting the SDF, because latency (`sdf_wait_max`) depends on the selection.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting ray-marcher cores (2..8).
- `MAX_LAT`, default 8: depth of the tag delay line; must exceed the largest `sdf_wait_max` in use.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous, active-high reset.
- `fractal_sel_in` in 3: requested fractal; may change at any cycle.
- `req_valid_in` in `N_REQ`: per-core query request.
- `req_point_in` in `N_REQ` x vec3: per-core query point.
- `req_ready_out` out `N_REQ`: one-hot grant; handshake = valid & ready.
- `resp_valid_out` out `N_REQ`: one-hot, 1-cycle pulse to the owning core.
- `resp_sdf_out` out fp: returned distance, broadcast to all cores; qualified by `resp_valid_out`.
- `sdf_point_out` out vec3: to `sdf_query.point_in`.
- `sdf_fractal_sel_out` out 3: to `sdf_query.fractal_sel_in` (the active selection).
- `sdf_in` in fp: from `sdf_query.sdf_out`.
- `sdf_wait_max_in` in 6: from `sdf_query.sdf_wait_max_out`, the SDF latency L.
- `busy_out` out 1: high when any query is in flight or a switch is pending.

## Operation
- State machine: RUN, DRAIN, SWITCH.
- RUN: grants the highest-priority valid requester. Priority is round-robin, starting at (last granted index + 1) mod `N_REQ`. `req_ready_out` is combinational from `req_valid_in`, the state and the pointer. It is never asserted to a non-requesting core, and it is all-zero unless the state is RUN.
- On a handshake at edge g:
  - `sdf_point_out` <= the granted point.
  - Tag {valid=1, id} is pushed into stage 0 of the delay line.
  - The pointer advances to the granted index.
- With no handshake, stage 0 receives valid=0 and `sdf_point_out` holds its value.
- Each cycle the delay line shifts one stage. The tag read at stage index L matches `sdf_in`. When that tag is valid, at the next edge:
  - `resp_sdf_out` <= `sdf_in`.
  - `resp_valid_out` <= onehot(id).
  - Otherwise `resp_valid_out` <= 0 and `resp_sdf_out` holds.
- L = `sdf_wait_max_in`, clamped to the range 1..`MAX_LAT`-1.
- In-flight counter: +1 on handshake, -1 on response, both in the same cycle = unchanged. Width is ceil(log2(`MAX_LAT`+1)).
- RUN -> DRAIN when `fractal_sel_in` != active selection. The arbiter issues no grant in the cycle the mismatch is seen.
- DRAIN: no grants. Moves to SWITCH when the in-flight counter is 0.
- SWITCH (1 cycle): active selection <= `fractal_sel_in`. The delay line is already empty. Then RUN.
- If `fractal_sel_in` reverts during DRAIN, the arbiter still completes DRAIN -> SWITCH. In that case SWITCH re-latches the same value.
- If `fractal_sel_in` changes again during SWITCH, it is caught as a mismatch in RUN on the following cycle.
- No response backpressure: cores must accept `resp_valid_out` unconditionally.

## Timing
- Reset values:
  - `req_ready_out`, `resp_valid_out`, `resp_sdf_out`, `sdf_point_out` = 0.
  - `sdf_fractal_sel_out` = 0, `busy_out` = 0.
  - State RUN, pointer such that core 0 has top priority, delay line all invalid, counter 0.
- Reset mid-operation drops all in-flight tags. No response is produced for them.
- Latency: handshake at edge g -> `sdf_point_out` valid in cycle g+1 -> `sdf_in` valid in cycle g+1+L -> `resp_valid_out` high in cycle g+2+L. For sel 0 (L=4) that is 6 cycles; for sel 1/2 (L=1) it is 3 cycles.
- Throughput: 1 query per cycle in RUN, with responses returned in issue order.
- Switch penalty: 1 mismatch cycle + drain time + 1 SWITCH cycle.
- `busy_out` = (counter != 0) | (state != RUN) | mismatch, registered.

## Test plan
- Reset, then core 0 alone requests with sel 1. Required: ready0 high; response pulse on `resp_valid_out[0]` exactly 3 cycles after the handshake edge, `resp_sdf_out` equal to the model's SDF of the point.
- All 4 cores request continuously with sel 0. Required: grants in order 0,1,2,3,0,…; one issue per cycle; each core's response arrives 6 cycles after its grant with the correct id.
- Cores 1 and 3 request, core 2 requests intermittently. Required: a requester is never starved beyond `N_REQ`-1 cycles; no grant goes to a non-valid core.
- Sel 0 -> 3 with 4 queries in flight. Required: grants stop at once; all 4 sel-0 responses are delivered; a single SWITCH cycle; `sdf_fractal_sel_out` becomes 3; the first new response arrives 7 cycles after the first post-switch grant.
- Reset asserted while 3 queries are in flight. Required: no `resp_valid_out` pulses afterward; `busy_out` is 0 the cycle after reset.
- Handshake and response in the same cycle with a change pulse of sel during DRAIN. Required: the counter stays consistent; the switch completes only when the counter reaches 0.
